// File: rtl/mmio_if.sv
// CPU-side MMIO bus: single-cycle read/write strobes with registered read data.
interface mmio_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       addr;
   logic              rd_en;
   logic              wr_en;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output addr, output rd_en, output wr_en, output wdata, input rdata);
   modport slave  (input addr, input rd_en, input wr_en, input wdata, output rdata);
endinterface

// File: rtl/mmio_hub.sv
// MMIO hub: per-channel receive FIFOs, status/overflow/irq-enable registers and
// output registers behind a 256-byte CPU window.
module mmio_hub #(
   parameter int          DATA_W     = 32,
   parameter int          N_IN       = 4,
   parameter int          FIFO_DEPTH = 8,
   parameter int          N_OUT      = 2,
   parameter logic [31:0] ADDR_BASE  = 32'hFFFF_FC00
) (
   input  logic                    clk,
   input  logic                    rst,
   mmio_if.slave                   bus,
   input  logic [N_IN-1:0]         in_valid,
   input  logic [N_IN*DATA_W-1:0]  in_data,
   output logic [N_IN-1:0]         in_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_strobe,
   output logic                    irq
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [N_IN][FIFO_DEPTH];
   logic [PTR_W-1:0]  head [N_IN];
   logic [PTR_W-1:0]  tail [N_IN];
   logic [CNT_W-1:0]  count [N_IN];
   logic [DATA_W-1:0] out_reg [N_OUT];
   logic [DATA_W-1:0] irq_en;
   logic [N_IN-1:0]   ovf;

   logic [N_IN-1:0]   full, nempty, push, pop, ovf_evt, ovf_clr;
   logic [31:0]       rel;
   logic              hit, rd_hit, wr_hit;
   logic [5:0]        widx;
   logic [DATA_W-1:0] status, rd_val;
   logic              unused_rel_lsb;

   // Offset relative to the window; anything beyond 0xFF wraps to a large value and misses.
   assign rel            = bus.addr - ADDR_BASE;
   assign hit            = (rel[31:8] == 24'h0);
   assign widx           = rel[7:2];
   assign unused_rel_lsb = ^rel[1:0];
   assign rd_hit         = bus.rd_en & hit;
   assign wr_hit         = bus.wr_en & hit;

   always_comb begin
      status  = '0;
      ovf_clr = (wr_hit && widx == 6'h12) ? bus.wdata[N_IN-1:0] : '0;
      for (int i = 0; i < N_IN; i++) begin
         full[i]         = (count[i] == CNT_W'(FIFO_DEPTH));
         nempty[i]       = (count[i] != '0);
         in_ready[i]     = !full[i] && !rst;
         push[i]         = in_valid[i] && in_ready[i];
         pop[i]          = rd_hit && (widx == 6'(i)) && nempty[i];
         ovf_evt[i]      = in_valid[i] && !in_ready[i] && !rst;
         status[i]       = nempty[i];
         status[16 + i]  = full[i];
      end
   end

   always_comb begin
      rd_val = '0;
      if (hit) begin
         for (int i = 0; i < N_IN; i++)
            if (widx == 6'(i) && nempty[i]) rd_val = mem[i][head[i]];
         if (widx == 6'h10) rd_val = status;
         if (widx == 6'h11) rd_val = irq_en;
         if (widx == 6'h12) rd_val = DATA_W'(ovf);
         for (int j = 0; j < N_OUT; j++)
            if (widx == 6'(32 + j)) rd_val = out_reg[j];
      end
   end

   always_comb begin
      out_data = '0;
      for (int j = 0; j < N_OUT; j++) out_data[j*DATA_W +: DATA_W] = out_reg[j];
   end

   // Storage needs no reset: occupancy counters alone define what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_IN; i++)
         if (push[i]) mem[i][tail[i]] <= in_data[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++) begin
            head[i]  <= '0;
            tail[i]  <= '0;
            count[i] <= '0;
         end
         for (int j = 0; j < N_OUT; j++) out_reg[j] <= '0;
         irq_en     <= '0;
         ovf        <= '0;
         out_strobe <= '0;
         irq        <= 1'b0;
         bus.rdata  <= '0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            if (push[i]) tail[i] <= tail[i] + PTR_W'(1);
            if (pop[i])  head[i] <= head[i] + PTR_W'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: count[i] <= count[i];
            endcase
         end
         // A fresh overflow beats a same-cycle W1C on the same bit.
         ovf <= (ovf & ~ovf_clr) | ovf_evt;
         if (wr_hit && widx == 6'h11) irq_en <= bus.wdata;
         out_strobe <= '0;
         for (int j = 0; j < N_OUT; j++) begin
            if (wr_hit && widx == 6'(32 + j)) begin
               out_reg[j]    <= bus.wdata;
               out_strobe[j] <= 1'b1;
            end
         end
         if (bus.rd_en) bus.rdata <= rd_val;
         irq <= |(nempty & irq_en[N_IN-1:0]);
      end
   end
endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 Parameter DATA_W, 32, data width of CPU bus, input channels and output registers.
REQ-002 Parameter N_IN, 4, number of input channels (1..8), each with its own receive FIFO.
REQ-003 Parameter FIFO_DEPTH, 8, entries per receive FIFO; power of two, 2..64.
REQ-004 Parameter N_OUT, 2, number of output registers (1..8).
REQ-005 Parameter ADDR_BASE, 32'hFFFF_FC00, base of the 256-byte MMIO window.
REQ-006 One clock; reset is synchronous and active-high: clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 addr  in  32  CPU byte address; only addr[7:2] decoded inside the window.
REQ-009 rd_en  in  1  CPU read strobe, one cycle per access.
REQ-010 wr_en  in  1  CPU write strobe, one cycle per access.
REQ-011 wdata  in  DATA_W  CPU write data.
REQ-012 rdata  out  DATA_W  registered read data.
REQ-013 in_valid  in  N_IN  per-channel producer valid.
REQ-014 in_data  in  N_IN*DATA_W  per-channel producer data, channel i at bits [i*DATA_W +: DATA_W].
REQ-015 in_ready  out  N_IN  per-channel FIFO not full.
REQ-016 out_data  out  N_OUT*DATA_W  output register contents, packed as in_data.
REQ-017 out_strobe  out  N_OUT  one-cycle pulse per output register write.
REQ-018 irq  out  1  registered interrupt request.

Function
REQ-019 Window hit SHALL be ADDR_BASE <= addr <= ADDR_BASE+0xFF; miss: reads return 0 next cycle, writes ignored, no state change.
REQ-020 Map (byte offset): 0x00+4i RX_DATA[i] (R); 0x40 STATUS (R); 0x44 IRQ_EN (RW); 0x48 OVF (R, W1C); 0x80+4j OUT[j] (RW); unmapped offsets read 0, writes ignored.
REQ-021 Read latency SHALL be exactly one cycle: rdata updates on the edge after rd_en, holds until next read.
REQ-022 RX_DATA[i] read with FIFO i non-empty SHALL return head and pop it on the same edge.
REQ-023 RX_DATA[i] read with FIFO i empty SHALL return 0 and not move pointers.
REQ-024 STATUS bit i = FIFO i non-empty; bit 16+i = FIFO i full; other bits 0.
REQ-025 in_ready[i] SHALL equal !full[i] (registered-state based), forced 0 while rst high.
REQ-026 Push SHALL occur when in_valid[i] & in_ready[i]; data written at tail, tail wraps modulo FIFO_DEPTH.
REQ-027 Simultaneous push and pop on one FIFO SHALL both occur; count unchanged; on empty FIFO, pop is suppressed (REQ-023) and push proceeds.
REQ-028 Full FIFO with pop and in_valid same cycle: push NOT accepted (in_ready=0), pop occurs, full clears next cycle.
REQ-029 in_valid[i] high while in_ready[i] low (not in reset) SHALL set OVF bit i; data discarded.
REQ-030 OVF write: bits with wdata=1 clear; a same-cycle overflow event on that bit SHALL win (bit stays 1).
REQ-031 OUT[j] write SHALL load out_data[j] and pulse out_strobe[j] high for exactly the next cycle; reads return current value.
REQ-032 rd_en and wr_en same cycle to same register: write takes effect, rdata returns the pre-write value.
REQ-033 rd_en and wr_en to RX_DATA: write ignored, read behaves per REQ-022/023.
REQ-034 irq SHALL be registered |(nonempty & IRQ_EN[N_IN-1:0]), one cycle after the causing state.
REQ-035 Occupancy counters SHALL be log2(FIFO_DEPTH)+1 bits; never exceed FIFO_DEPTH nor underflow.

Reset
REQ-036 While rst high at a clock edge: all FIFOs empty, pointers 0, rdata 0, out_data 0, out_strobe 0, IRQ_EN 0, OVF 0, irq 0.
REQ-037 Reset mid-operation SHALL discard FIFO contents and cancel any pending out_strobe; in-flight read returns 0.

Verification
REQ-038 Push 0x11,0x22,0x33 on ch0; read 0xFFFF_FC00 x4 -> rdata 0x11,0x22,0x33,0 on successive cycles after each rd_en.
REQ-039 Push 9 words to ch1 (depth 8) -> in_ready[1]=0 after 8th, STATUS bit17=1, OVF=0x2; write OVF 0x2 -> OVF=0.
REQ-040 Full ch2, same cycle pop and in_valid -> head returned, word not stored, in_ready[2]=1 next cycle, count 7.
REQ-041 Write 0xDEADBEEF to 0xFFFF_FC84 -> out_data[1]=0xDEADBEEF, out_strobe=2'b10 for one cycle; read back 0xDEADBEEF.
REQ-042 IRQ_EN=0x1, push to ch0 -> irq=1 one cycle after push; pop last word -> irq=0 next cycle.
REQ-043 Assert rst with 5 words in ch3 and OUT[0]=0x5 -> STATUS=0, out_data=0, irq=0 after one edge; access to 0x0000_1000 -> rdata 0.
